can_rx_frame: RTL and testbench
===============================

Name: can_rx_frame

Overview:
- Receive-side frame engine of the CAN controller; the stage downstream of the transmitter on the shared bus.
- Consumes one sampled bus bit per sample-point pulse from the bit-timing stage.
- Removes stuff bits, checks CRC-15 and frame form, and drives the ACK slot.
- Presents a completed frame (id, format, rtr, datalen, data) in the same field layout the transmitter accepts.

Parameters:
- INTEG_BITS, 11, consecutive recessive bits required before SOF is accepted (bus integration / error recovery).
- EOF_BITS, 7, recessive end-of-frame bits checked before the frame is delivered.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- bit_valid  in  1  one-cycle pulse at each bit sample point
- bit_in  in  1  sampled bus level (1 = recessive, 0 = dominant); valid only with bit_valid
- ack_drive  out  1  request to drive dominant during the ACK slot
- busy  out  1  high from SOF until frame end or error
- rx_valid  out  1  one-cycle pulse: frame complete and error-free
- rx_id  out  29  identifier; base frames occupy [28:18] with [17:0] = 0
- rx_format  out  1  1 = extended frame
- rx_rtr  out  1  1 = remote frame
- rx_datalen  out  4  received DLC
- rx_data  out  64  payload; first received bit lands in [63]; unused low bits = 0
- rx_stuff_err  out  1  one-cycle error pulse
- rx_crc_err  out  1  one-cycle error pulse
- rx_form_err  out  1  one-cycle error pulse

Behaviour:
- Reset values:
  - State = S_INTEG; all counters and the CRC = 0.
  - All outputs 0, except rx_id/rx_data/rx_datalen/rx_format/rx_rtr, which are also 0.
- State advances only on bit_valid; all other cycles hold.
- Reset asserted mid-frame aborts silently: no rx_valid, no error pulse; the block re-enters S_INTEG.
- S_INTEG / S_ERRWAIT:
  - Count consecutive 1s; any 0 clears the count.
  - At INTEG_BITS, go to S_IDLE.
  - S_ERRWAIT is entered on any error.
- S_IDLE: a bit of 0 is SOF.
  - Clear the CRC and the staging registers.
  - Set busy; go to S_IDA.
- Destuffing:
  - Active from SOF through the last CRC bit inclusive.
  - Track the run length of equal bits; SOF starts a run of 1.
  - After 5 equal bits, the next bit is a stuff bit.
  - Opposite polarity: discard it; it starts a new run of 1.
  - Same polarity: pulse rx_stuff_err, go to S_ERRWAIT.
  - Stuff bits are never fed to the CRC or the field logic.
  - A stuff bit following the 15th CRC bit is consumed before the delimiter.
- CRC:
  - 15-bit, polynomial 0x4599, initial value 0, MSB-first shift.
  - Covers destuffed bits from SOF through the last data bit.
  - Update per bit: nx = crc[14] ^ bit; crc = {crc[13:0],0} ^ (nx ? 0x4599 : 0).
- Field sequence (destuffed bits, MSB first):
  - S_IDA: 11 bits → id[28:18].
  - S_SRR: 1 bit, held as provisional RTR.
  - S_IDE, base (IDE=0):
    - rtr = provisional bit.
    - S_R0: 1 bit, any value.
    - then S_DLC.
  - S_IDE, extended (IDE=1):
    - S_IDB: 18 bits → id[17:0].
    - S_RTR: 1 bit.
    - S_R1, S_R0: reserved bits, any value.
    - then S_DLC.
  - S_DLC: 4 bits.
  - Payload length: nbytes = min(DLC,8), forced to 0 when rtr = 1.
  - nbytes = 0: skip directly to S_CRC.
  - S_DATA: nbytes*8 bits.
  - S_CRC: 15 bits, compared against the running CRC.
- S_CRCDEL:
  - Bit must be 1, else pulse rx_form_err → S_ERRWAIT.
  - On its sample, if the CRC matched: set ack_drive.
- S_ACK:
  - Clear ack_drive on the ACK-slot sample, so ack_drive spans exactly one bit time.
  - The sampled ACK value is ignored.
- S_ACKDEL:
  - Bit must be 1, else rx_form_err.
  - Then, if the CRC mismatched: pulse rx_crc_err → S_ERRWAIT.
- S_EOF:
  - EOF_BITS bits, all must be 1, else rx_form_err.
  - After the last one: copy staging to the rx_* outputs, pulse rx_valid the next cycle, clear busy, go to S_IDLE.
- Output stability:
  - rx_* fields change only with rx_valid and hold until the next good frame.
  - Errors never disturb the rx_* fields.
- Error handling:
  - At most one error pulse per frame; clear busy and ack_drive.
- DLC 9..15: reported unmodified on rx_datalen; 64 data bits received.

Test Plan:
1. Base data frame, id 0x123, DLC 2, data 0xA55A, correct stuffing/CRC → ack_drive high for one ACK bit time, rx_valid pulse, rx_id[28:18]=0x123, rx_id[17:0]=0, rx_format=0, rx_rtr=0, rx_datalen=2, rx_data=0xA55A000000000000.
2. Base frame id 0x000, DLC 0 (dominant runs force stuff bits) → stuff bits removed, rx_valid with rx_id=0. Same frame with one stuff bit sent non-inverted → rx_stuff_err pulse, no rx_valid, no ack_drive; next frame accepted only after 11 recessive bits.
3. Frame from test 1 with CRC bit 7 inverted → ack_drive never asserts; rx_crc_err pulse at the ACK-delimiter sample; rx_* outputs unchanged from the previous frame.
4. Extended remote frame, id 0x1ABCDEF0, DLC 4 → no data bits consumed, rx_format=1, rx_rtr=1, rx_datalen=4, rx_data=0. Separately, DLC=15 data frame → 64 data bits, rx_datalen=15.
5. CRC delimiter or 3rd EOF bit forced dominant → rx_form_err pulse, no rx_valid.
6. rst asserted during S_DATA → no pulses. A SOF after only 5 recessive bits is ignored; a SOF after 11 recessive bits is received normally.

Source files
------------

// File: rtl/can_rx_frame.sv
// -----------------------------------------------------------------------------
// can_rx_frame
//
// Receive-side frame engine of the CAN controller. It consumes one sampled bus
// bit per sample-point pulse, removes stuff bits, tracks the frame fields,
// checks CRC-15 and the fixed-form bits, drives the ACK slot, and presents a
// completed frame in the same field layout the transmitter accepts.
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   bit_valid     one-cycle pulse at each bit sample point
//   bit_in        sampled bus level (1 = recessive, 0 = dominant)
//   ack_drive     request to drive dominant during the ACK slot
//   busy          high from SOF until frame end or error
//   rx_valid      one-cycle pulse: frame complete and error-free
//   rx_id         identifier; base frames in [28:18], [17:0] = 0
//   rx_format     1 = extended frame
//   rx_rtr        1 = remote frame
//   rx_datalen    received DLC (unmodified, 0..15)
//   rx_data       payload, first received bit in [63], unused low bits 0
//   rx_stuff_err  one-cycle stuff-error pulse
//   rx_crc_err    one-cycle CRC-error pulse
//   rx_form_err   one-cycle form-error pulse
// -----------------------------------------------------------------------------
module can_rx_frame #(
  parameter int INTEG_BITS = 11,
  parameter int EOF_BITS   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_valid,
  input  logic        bit_in,
  output logic        ack_drive,
  output logic        busy,
  output logic        rx_valid,
  output logic [28:0] rx_id,
  output logic        rx_format,
  output logic        rx_rtr,
  output logic [3:0]  rx_datalen,
  output logic [63:0] rx_data,
  output logic        rx_stuff_err,
  output logic        rx_crc_err,
  output logic        rx_form_err
);

  localparam int          ICW      = $clog2(INTEG_BITS + 1);
  localparam logic [14:0] CRC_POLY = 15'h4599;

  typedef enum logic [4:0] {
    S_INTEG,
    S_ERRWAIT,
    S_IDLE,
    S_IDA,
    S_SRR,
    S_IDE,
    S_IDB,
    S_RTR,
    S_R1,
    S_R0,
    S_DLC,
    S_DATA,
    S_CRC,
    S_CRCDEL,
    S_ACK,
    S_ACKDEL,
    S_EOF
  } state_e;

  // Payload bytes implied by a DLC: capped at 8, none for remote frames.
  function automatic logic [3:0] nbytes_f(input logic [3:0] dlc, input logic rtr);
    logic [3:0] n;
    n = (dlc > 4'd8) ? 4'd8 : dlc;
    return rtr ? 4'd0 : n;
  endfunction

  // Frame control
  state_e           state_q, state_d;
  logic [ICW-1:0]   integ_cnt_q, integ_cnt_d;
  logic [6:0]       bit_cnt_q, bit_cnt_d;
  logic [2:0]       run_cnt_q, run_cnt_d;
  logic             last_bit_q, last_bit_d;
  logic [14:0]      crc_q, crc_d;
  logic [14:0]      crc_rx_q, crc_rx_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;

  // Staging registers for the frame being received
  logic [10:0]      ida_q, ida_d;
  logic [17:0]      idb_q, idb_d;
  logic             srr_q, srr_d;
  logic             ide_q, ide_d;
  logic             rtr_q, rtr_d;
  logic [3:0]       dlc_q, dlc_d;
  logic [63:0]      data_q, data_d;

  // Delivered frame and status pulses
  logic             rx_valid_q, rx_valid_d;
  logic             stuff_err_q, stuff_err_d;
  logic             crc_err_q, crc_err_d;
  logic             form_err_q, form_err_d;
  logic [28:0]      out_id_q, out_id_d;
  logic             out_format_q, out_format_d;
  logic             out_rtr_q, out_rtr_d;
  logic [3:0]       out_dlc_q, out_dlc_d;
  logic [63:0]      out_data_q, out_data_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_INTEG;
      integ_cnt_q  <= '0;
      bit_cnt_q    <= '0;
      run_cnt_q    <= '0;
      last_bit_q   <= 1'b0;
      crc_q        <= '0;
      crc_rx_q     <= '0;
      busy_q       <= 1'b0;
      ack_q        <= 1'b0;
      ida_q        <= '0;
      idb_q        <= '0;
      srr_q        <= 1'b0;
      ide_q        <= 1'b0;
      rtr_q        <= 1'b0;
      dlc_q        <= '0;
      data_q       <= '0;
      rx_valid_q   <= 1'b0;
      stuff_err_q  <= 1'b0;
      crc_err_q    <= 1'b0;
      form_err_q   <= 1'b0;
      out_id_q     <= '0;
      out_format_q <= 1'b0;
      out_rtr_q    <= 1'b0;
      out_dlc_q    <= '0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      integ_cnt_q  <= integ_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      run_cnt_q    <= run_cnt_d;
      last_bit_q   <= last_bit_d;
      crc_q        <= crc_d;
      crc_rx_q     <= crc_rx_d;
      busy_q       <= busy_d;
      ack_q        <= ack_d;
      ida_q        <= ida_d;
      idb_q        <= idb_d;
      srr_q        <= srr_d;
      ide_q        <= ide_d;
      rtr_q        <= rtr_d;
      dlc_q        <= dlc_d;
      data_q       <= data_d;
      rx_valid_q   <= rx_valid_d;
      stuff_err_q  <= stuff_err_d;
      crc_err_q    <= crc_err_d;
      form_err_q   <= form_err_d;
      out_id_q     <= out_id_d;
      out_format_q <= out_format_d;
      out_rtr_q    <= out_rtr_d;
      out_dlc_q    <= out_dlc_d;
      out_data_q   <= out_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic        in_stuff_region;
  logic        in_crc_region;
  logic        stuff_pending;
  logic        crc_nx;
  logic [14:0] crc_upd;
  logic        crc_match;
  logic [6:0]  data_last_idx;
  logic [3:0]  dlc_new;
  logic        go_err;

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d       = state_q;
    integ_cnt_d   = integ_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    run_cnt_d     = run_cnt_q;
    last_bit_d    = last_bit_q;
    crc_d         = crc_q;
    crc_rx_d      = crc_rx_q;
    busy_d        = busy_q;
    ack_d         = ack_q;
    ida_d         = ida_q;
    idb_d         = idb_q;
    srr_d         = srr_q;
    ide_d         = ide_q;
    rtr_d         = rtr_q;
    dlc_d         = dlc_q;
    data_d        = data_q;
    rx_valid_d    = 1'b0;
    stuff_err_d   = 1'b0;
    crc_err_d     = 1'b0;
    form_err_d    = 1'b0;
    out_id_d      = out_id_q;
    out_format_d  = out_format_q;
    out_rtr_d     = out_rtr_q;
    out_dlc_d     = out_dlc_q;
    out_data_d    = out_data_q;
    go_err        = 1'b0;

    in_stuff_region = (state_q == S_IDA)  || (state_q == S_SRR) ||
                      (state_q == S_IDE)  || (state_q == S_IDB) ||
                      (state_q == S_RTR)  || (state_q == S_R1)  ||
                      (state_q == S_R0)   || (state_q == S_DLC) ||
                      (state_q == S_DATA) || (state_q == S_CRC);
    in_crc_region   = in_stuff_region && (state_q != S_CRC);
    // A stuff bit that follows the last CRC bit is still owed in S_CRCDEL.
    stuff_pending   = (run_cnt_q == 3'd5) &&
                      (in_stuff_region || (state_q == S_CRCDEL));

    crc_nx        = crc_q[14] ^ bit_in;
    crc_upd       = {crc_q[13:0], 1'b0} ^ (crc_nx ? CRC_POLY : 15'h0000);
    crc_match     = (crc_rx_q == crc_q);
    data_last_idx = {nbytes_f(dlc_q, rtr_q), 3'b000} - 7'd1;
    dlc_new       = {dlc_q[2:0], bit_in};

    if (bit_valid) begin
      case (state_q)
        S_INTEG, S_ERRWAIT: begin
          if (bit_in) begin
            if (integ_cnt_q == ICW'(INTEG_BITS - 1)) begin
              integ_cnt_d = '0;
              state_d     = S_IDLE;
            end else begin
              integ_cnt_d = integ_cnt_q + 1'b1;
            end
          end else begin
            integ_cnt_d = '0;
          end
        end

        S_IDLE: begin
          if (!bit_in) begin
            // SOF: the CRC of a single dominant bit from zero is zero, so
            // clearing the CRC also accounts for the SOF bit.
            crc_d      = '0;
            crc_rx_d   = '0;
            ida_d      = '0;
            idb_d      = '0;
            srr_d      = 1'b0;
            ide_d      = 1'b0;
            rtr_d      = 1'b0;
            dlc_d      = '0;
            data_d     = '0;
            run_cnt_d  = 3'd1;
            last_bit_d = 1'b0;
            bit_cnt_d  = '0;
            busy_d     = 1'b1;
            state_d    = S_IDA;
          end
        end

        default: begin
          if (stuff_pending) begin
            if (bit_in == last_bit_q) begin
              stuff_err_d = 1'b1;
              go_err      = 1'b1;
            end else begin
              run_cnt_d  = 3'd1;
              last_bit_d = bit_in;
            end
          end else begin
            if (in_stuff_region) begin
              if (bit_in == last_bit_q) begin
                run_cnt_d = run_cnt_q + 3'd1;
              end else begin
                run_cnt_d  = 3'd1;
                last_bit_d = bit_in;
              end
            end
            if (in_crc_region) begin
              crc_d = crc_upd;
            end

            case (state_q)
              S_IDA: begin
                ida_d = {ida_q[9:0], bit_in};
                if (bit_cnt_q == 7'd10) begin
                  bit_cnt_d = '0;
                  state_d   = S_SRR;
                end else begin
                  bit_cnt_d = bit_cnt_q + 7'd1;
                end
              end
              S_SRR: begin
                // Base frames carry RTR here; extended frames carry SRR.
                srr_d   = bit_in;
                state_d = S_IDE;
              end
              S_IDE: begin
                ide_d = bit_in;
                if (bit_in) begin
                  bit_cnt_d = '0;
                  state_d   = S_IDB;
                end else begin
                  rtr_d   = srr_q;
                  state_d = S_R0;
                end
              end
              S_IDB: begin
                idb_d = {idb_q[16:0], bit_in};
                if (bit_cnt_q == 7'd17) begin
                  bit_cnt_d = '0;
                  state_d   = S_RTR;
                end else begin
                  bit_cnt_d = bit_cnt_q + 7'd1;
                end
              end
              S_RTR: begin
                rtr_d   = bit_in;
                state_d = S_R1;
              end
              S_R1: begin
                state_d = S_R0;
              end
              S_R0: begin
                bit_cnt_d = '0;
                state_d   = S_DLC;
              end
              S_DLC: begin
                dlc_d = dlc_new;
                if (bit_cnt_q == 7'd3) begin
                  bit_cnt_d = '0;
                  state_d   = (nbytes_f(dlc_new, rtr_q) == 4'd0) ? S_CRC : S_DATA;
                end else begin
                  bit_cnt_d = bit_cnt_q + 7'd1;
                end
              end
              S_DATA: begin
                data_d[6'd63 - bit_cnt_q[5:0]] = bit_in;
                if (bit_cnt_q == data_last_idx) begin
                  bit_cnt_d = '0;
                  state_d   = S_CRC;
                end else begin
                  bit_cnt_d = bit_cnt_q + 7'd1;
                end
              end
              S_CRC: begin
                crc_rx_d = {crc_rx_q[13:0], bit_in};
                if (bit_cnt_q == 7'd14) begin
                  bit_cnt_d = '0;
                  state_d   = S_CRCDEL;
                end else begin
                  bit_cnt_d = bit_cnt_q + 7'd1;
                end
              end
              S_CRCDEL: begin
                if (!bit_in) begin
                  form_err_d = 1'b1;
                  go_err     = 1'b1;
                end else begin
                  ack_d   = crc_match;
                  state_d = S_ACK;
                end
              end
              S_ACK: begin
                ack_d   = 1'b0;
                state_d = S_ACKDEL;
              end
              S_ACKDEL: begin
                if (!bit_in) begin
                  form_err_d = 1'b1;
                  go_err     = 1'b1;
                end else if (!crc_match) begin
                  crc_err_d = 1'b1;
                  go_err    = 1'b1;
                end else begin
                  bit_cnt_d = '0;
                  state_d   = S_EOF;
                end
              end
              S_EOF: begin
                if (!bit_in) begin
                  form_err_d = 1'b1;
                  go_err     = 1'b1;
                end else if (bit_cnt_q == 7'(EOF_BITS - 1)) begin
                  out_id_d     = {ida_q, idb_q};
                  out_format_d = ide_q;
                  out_rtr_d    = rtr_q;
                  out_dlc_d    = dlc_q;
                  out_data_d   = data_q;
                  rx_valid_d   = 1'b1;
                  busy_d       = 1'b0;
                  bit_cnt_d    = '0;
                  state_d      = S_IDLE;
                end else begin
                  bit_cnt_d = bit_cnt_q + 7'd1;
                end
              end
              default: begin
                state_d = S_INTEG;
              end
            endcase
          end
        end
      endcase
    end

    // Any error abandons the frame and waits for bus integration again.
    if (go_err) begin
      state_d     = S_ERRWAIT;
      busy_d      = 1'b0;
      ack_d       = 1'b0;
      integ_cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    ack_drive    = ack_q;
    busy         = busy_q;
    rx_valid     = rx_valid_q;
    rx_id        = out_id_q;
    rx_format    = out_format_q;
    rx_rtr       = out_rtr_q;
    rx_datalen   = out_dlc_q;
    rx_data      = out_data_q;
    rx_stuff_err = stuff_err_q;
    rx_crc_err   = crc_err_q;
    rx_form_err  = form_err_q;
  end

endmodule

// File: tb/tb_can_rx_frame.sv
// -----------------------------------------------------------------------------
// tb_can_rx_frame
//
// Directed bench for can_rx_frame. A small transmitter model assembles each
// frame (fields, CRC-15, bit stuffing, fixed-form tail) with optional faults,
// plays it one bit per four clocks, and compares the delivered fields and the
// pulse counts against hand-written expectations.
// -----------------------------------------------------------------------------
module tb_can_rx_frame;

  localparam int F_NONE   = 0;
  localparam int F_CRC7   = 1;
  localparam int F_STUFF  = 2;
  localparam int F_CRCDEL = 3;
  localparam int F_EOF3   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_valid;
  logic        bit_in;
  logic        ack_drive;
  logic        busy;
  logic        rx_valid;
  logic [28:0] rx_id;
  logic        rx_format;
  logic        rx_rtr;
  logic [3:0]  rx_datalen;
  logic [63:0] rx_data;
  logic        rx_stuff_err;
  logic        rx_crc_err;
  logic        rx_form_err;

  always #5 clk = ~clk;

  can_rx_frame #(
    .INTEG_BITS(11),
    .EOF_BITS  (7)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .ack_drive   (ack_drive),
    .busy        (busy),
    .rx_valid    (rx_valid),
    .rx_id       (rx_id),
    .rx_format   (rx_format),
    .rx_rtr      (rx_rtr),
    .rx_datalen  (rx_datalen),
    .rx_data     (rx_data),
    .rx_stuff_err(rx_stuff_err),
    .rx_crc_err  (rx_crc_err),
    .rx_form_err (rx_form_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse / level monitor, sampled on the falling edge.
  int n_valid = 0, n_stuff = 0, n_crc = 0, n_form = 0, n_ack = 0;
  always @(negedge clk) begin
    if (rx_valid)     n_valid++;
    if (rx_stuff_err) n_stuff++;
    if (rx_crc_err)   n_crc++;
    if (rx_form_err)  n_form++;
    if (ack_drive)    n_ack++;
  end

  int s_valid, s_stuff, s_crc, s_form, s_ack;

  task automatic snap();
    s_valid = n_valid;
    s_stuff = n_stuff;
    s_crc   = n_crc;
    s_form  = n_form;
    s_ack   = n_ack;
  endtask

  task automatic check_pulses(input string tag, input int e_valid, input int e_stuff,
                              input int e_crc, input int e_form, input int e_ack);
    check({tag, "_valid"}, 64'(n_valid - s_valid), 64'(e_valid));
    check({tag, "_stuff"}, 64'(n_stuff - s_stuff), 64'(e_stuff));
    check({tag, "_crc"},   64'(n_crc - s_crc),     64'(e_crc));
    check({tag, "_form"},  64'(n_form - s_form),   64'(e_form));
    check({tag, "_ack"},   64'(n_ack - s_ack),     64'(e_ack));
  endtask

  task automatic check_frame(input string tag, input logic [28:0] id, input logic fmt,
                             input logic rtr, input logic [3:0] dlc, input logic [63:0] data);
    check({tag, "_id"},   64'(rx_id), 64'(id));
    check({tag, "_fmt"},  64'(rx_format), 64'(fmt));
    check({tag, "_rtr"},  64'(rx_rtr), 64'(rtr));
    check({tag, "_dlc"},  64'(rx_datalen), 64'(dlc));
    check({tag, "_data"}, rx_data, data);
  endtask

  // Transmitter model -------------------------------------------------------
  logic raw_q[$];
  logic tx_q[$];

  task automatic build_frame(input logic [28:0] id, input logic ext, input logic rtr,
                             input logic [3:0] dlc, input logic [63:0] data, input int fault);
    logic [14:0] crc;
    logic        nx;
    logic        last;
    int          nbits;
    int          run;
    raw_q.delete();
    tx_q.delete();
    raw_q.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw_q.push_back(id[18 + i]);
    if (ext) begin
      raw_q.push_back(1'b1);
      raw_q.push_back(1'b1);
      for (int i = 17; i >= 0; i--) raw_q.push_back(id[i]);
      raw_q.push_back(rtr);
      raw_q.push_back(1'b0);
      raw_q.push_back(1'b0);
    end else begin
      raw_q.push_back(rtr);
      raw_q.push_back(1'b0);
      raw_q.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) raw_q.push_back(dlc[i]);
    nbits = rtr ? 0 : ((dlc > 4'd8) ? 64 : int'(dlc) * 8);
    for (int i = 0; i < nbits; i++) raw_q.push_back(data[63 - i]);
    crc = '0;
    foreach (raw_q[i]) begin
      nx  = crc[14] ^ raw_q[i];
      crc = {crc[13:0], 1'b0};
      if (nx) crc = crc ^ 15'h4599;
    end
    if (fault == F_CRC7) crc[7] = ~crc[7];
    for (int i = 14; i >= 0; i--) raw_q.push_back(crc[i]);
    run  = 0;
    last = 1'b1;
    foreach (raw_q[i]) begin
      tx_q.push_back(raw_q[i]);
      if (raw_q[i] == last) run++;
      else begin
        run  = 1;
        last = raw_q[i];
      end
      if (run == 5) begin
        if (fault == F_STUFF) begin
          tx_q.push_back(last);
          return;
        end
        tx_q.push_back(~last);
        run  = 1;
        last = ~last;
      end
    end
    tx_q.push_back(fault == F_CRCDEL ? 1'b0 : 1'b1);
    tx_q.push_back(1'b1);
    tx_q.push_back(1'b1);
    for (int i = 0; i < 7; i++) tx_q.push_back((fault == F_EOF3 && i == 2) ? 1'b0 : 1'b1);
    for (int i = 0; i < 3; i++) tx_q.push_back(1'b1);
  endtask

  // One bit every four clocks; entered and left at posedge + 1.
  task automatic send_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    @(posedge clk);
    #1 bit_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_tx(input int n);
    for (int i = 0; i < n && i < tx_q.size(); i++) send_bit(tx_q[i]);
  endtask

  localparam logic [28:0] ID1   = {11'h123, 18'h0};
  localparam logic [63:0] DATA1 = 64'hA55A_0000_0000_0000;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    bit_valid = 1'b0;
    bit_in    = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ack", 64'(ack_drive), 64'd0);
    check("rst_valid", 64'(rx_valid), 64'd0);
    check("rst_errs", 64'({rx_stuff_err, rx_crc_err, rx_form_err}), 64'd0);
    check_frame("rst", 29'h0, 1'b0, 1'b0, 4'd0, 64'h0);

    // Test 1: base data frame.
    send_idle(11);
    snap();
    build_frame(ID1, 1'b0, 1'b0, 4'd2, DATA1, F_NONE);
    send_tx(tx_q.size());
    check_pulses("t1", 1, 0, 0, 0, 4);
    check_frame("t1", ID1, 1'b0, 1'b0, 4'd2, DATA1);
    check("t1_busy_end", 64'(busy), 64'd0);

    // Test 3: CRC bit 7 inverted -> CRC error, fields held.
    send_idle(12);
    snap();
    build_frame(ID1, 1'b0, 1'b0, 4'd2, DATA1, F_CRC7);
    send_tx(tx_q.size());
    check_pulses("t3", 0, 0, 1, 0, 0);
    check_frame("t3_hold", ID1, 1'b0, 1'b0, 4'd2, DATA1);

    // Test 2a: all-dominant base frame, heavy stuffing.
    send_idle(12);
    snap();
    build_frame(29'h0, 1'b0, 1'b0, 4'd0, 64'h0, F_NONE);
    send_tx(tx_q.size());
    check_pulses("t2a", 1, 0, 0, 0, 4);
    check_frame("t2a", 29'h0, 1'b0, 1'b0, 4'd0, 64'h0);

    // Test 2b: first stuff bit sent with the wrong polarity.
    send_idle(12);
    snap();
    build_frame(29'h0, 1'b0, 1'b0, 4'd0, 64'h0, F_STUFF);
    send_tx(tx_q.size());
    send_idle(3);
    check_pulses("t2b", 0, 1, 0, 0, 0);
    check("t2b_busy", 64'(busy), 64'd0);
    // 3 + 7 = 10 recessive bits: a dominant bit now is not a SOF.
    send_idle(7);
    send_bit(1'b0);
    check("t2b_no_sof_busy", 64'(busy), 64'd0);
    send_idle(11);
    snap();
    build_frame(ID1, 1'b0, 1'b0, 4'd2, DATA1, F_NONE);
    send_tx(tx_q.size());
    check_pulses("t2b_after", 1, 0, 0, 0, 4);
    check_frame("t2b_after", ID1, 1'b0, 1'b0, 4'd2, DATA1);

    // Test 4a: extended remote frame, DLC 4, no data bits.
    send_idle(12);
    snap();
    build_frame(29'h1ABCDEF0, 1'b1, 1'b1, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, F_NONE);
    send_tx(tx_q.size());
    check_pulses("t4a", 1, 0, 0, 0, 4);
    check_frame("t4a", 29'h1ABCDEF0, 1'b1, 1'b1, 4'd4, 64'h0);

    // Test 4b: DLC 15 data frame carries 64 data bits.
    send_idle(12);
    snap();
    build_frame({11'h555, 18'h0}, 1'b0, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF, F_NONE);
    send_tx(tx_q.size());
    check_pulses("t4b", 1, 0, 0, 0, 4);
    check_frame("t4b", {11'h555, 18'h0}, 1'b0, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF);

    // Test 5a: CRC delimiter dominant.
    send_idle(12);
    snap();
    build_frame(ID1, 1'b0, 1'b0, 4'd2, DATA1, F_CRCDEL);
    send_tx(tx_q.size());
    check_pulses("t5a", 0, 0, 0, 1, 0);
    check_frame("t5a_hold", {11'h555, 18'h0}, 1'b0, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF);

    // Test 5b: third EOF bit dominant.
    send_idle(12);
    snap();
    build_frame(ID1, 1'b0, 1'b0, 4'd2, DATA1, F_EOF3);
    send_tx(tx_q.size());
    check_pulses("t5b", 0, 0, 0, 1, 4);
    check("t5b_busy", 64'(busy), 64'd0);

    // Test 6: reset during the data field aborts silently.
    send_idle(12);
    snap();
    build_frame(ID1, 1'b0, 1'b0, 4'd2, DATA1, F_NONE);
    send_tx(26);
    check("t6_busy_mid", 64'(busy), 64'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_pulses("t6_rst", 0, 0, 0, 0, 0);
    check("t6_busy_rst", 64'(busy), 64'd0);
    check("t6_id_rst", 64'(rx_id), 64'd0);
    send_idle(5);
    send_bit(1'b0);
    check("t6_no_sof_busy", 64'(busy), 64'd0);
    send_idle(11);
    snap();
    build_frame(ID1, 1'b0, 1'b0, 4'd2, DATA1, F_NONE);
    send_tx(tx_q.size());
    check_pulses("t6_after", 1, 0, 0, 0, 4);
    check_frame("t6_after", ID1, 1'b0, 1'b0, 4'd2, DATA1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
